mult_sequencer: RTL

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_pkg.sv | 19 +
 rtl/step_counter.sv | 41 ++++
 rtl/mult_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the add-shift multiplier sequencer:
//   WIDTH_DEFAULT - default multiplier operand width in bits (legal 2..16)
//   state_t       - sequencer states
// ---------------------------------------------------------------------------
package mult_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE,    // waiting for Run; ClearA_LoadB honoured here only
      CLEAR,   // one cycle: clear A/X, zero the step counter
      ADD,     // conditional add (steps 0..WIDTH-2) or subtract (last step)
      SHIFT,   // arithmetic right shift of X:A:B
      HALT     // result valid; wait for Run to drop
   } state_t;

endpackage

// File: rtl/step_counter.sv
// ---------------------------------------------------------------------------
// step_counter
// Counts completed add/shift steps of one multiply.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset (count -> 0)
//   clear  in  synchronous clear to 0
//   inc    in  synchronous increment (clear has priority)
//   tc     out terminal count: count == WIDTH-1 (last step)
// ---------------------------------------------------------------------------
module step_counter
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic tc
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0] count;

   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CW'(1);
      end
   end

   assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_sequencer.sv
// ---------------------------------------------------------------------------
// mult_sequencer
// Control FSM for a WIDTH-bit signed add-shift multiplier. The datapath holds
// X (sign extension), A (accumulator) and B (multiplier); this block only
// decodes the control strobes.
// Ports:
//   Clk           in  rising-edge clock
//   Reset_n       in  asynchronous active-low reset
//   Run           in  level request to start a multiply
//   ClearA_LoadB  in  level request to clear A/X and load B (IDLE only)
//   M             in  current LSB of B
//   Clr_Ld        out clear A/X and load B
//   Clr_A         out clear A/X, keep B
//   Add_En        out A <= A + S
//   Sub_En        out A <= A - S (last step, B sign bit)
//   Shift_En      out arithmetic right shift of X:A:B
//   Done          out result valid in X:A:B
//   Busy          out multiply in progress
// All outputs are unregistered decodes of state, step count and M.
// ---------------------------------------------------------------------------
module mult_sequencer
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic Clr_Ld,
   output logic Clr_A,
   output logic Add_En,
   output logic Sub_En,
   output logic Shift_En,
   output logic Done,
   output logic Busy
);

   state_t state;
   state_t next_state;
   logic   cnt_clear;
   logic   cnt_inc;
   logic   last_step;

   step_counter #(
      .WIDTH (WIDTH)
   ) u_step_counter (
      .clk   (Clk),
      .rst_n (Reset_n),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .tc    (last_step)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every signal written here gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      next_state = state;
      cnt_clear  = 1'b0;
      cnt_inc    = 1'b0;
      Clr_Ld     = 1'b0;
      Clr_A      = 1'b0;
      Add_En     = 1'b0;
      Sub_En     = 1'b0;
      Shift_En   = 1'b0;
      Done       = 1'b0;
      Busy       = 1'b0;

      case (state)
         IDLE: begin
            // Run beats a simultaneous load request. Reset_n gating keeps
            // Clr_Ld quiet while reset holds the FSM in IDLE.
            Clr_Ld = Reset_n & ClearA_LoadB & ~Run;
            if (Run) begin
               next_state = CLEAR;
            end
         end

         CLEAR: begin
            Clr_A      = 1'b1;
            cnt_clear  = 1'b1;
            Busy       = 1'b1;
            next_state = ADD;
         end

         ADD: begin
            // The multiplier MSB has negative weight, so its partial
            // product is subtracted instead of added.
            Add_En     = M & ~last_step;
            Sub_En     = M & last_step;
            Busy       = 1'b1;
            next_state = SHIFT;
         end

         SHIFT: begin
            Shift_En = 1'b1;
            Busy     = 1'b1;
            if (last_step) begin
               next_state = HALT;
            end else begin
               cnt_inc    = 1'b1;
               next_state = ADD;
            end
         end

         HALT: begin
            Done = 1'b1;
            if (!Run) begin
               next_state = IDLE;
            end
         end

         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule
